// File: rtl/sync_decoder_pkg.sv
// Shared constants for sync_decoder: lock FSM state encodings, counter widths and the
// default 640x480 geometry.
package sync_decoder_pkg;

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam int unsigned GOOD_W = 4;
    localparam int unsigned HTOT_W = 16;

    localparam int DEF_CORDW = 10;
    localparam int DEF_H_RES = 640;
    localparam int DEF_V_RES = 480;

endpackage

// File: rtl/sync_edge.sv
// Input register stage for one sync-type signal: normalises to active-high, registers it and
// produces assertion/deassertion edge pulses aligned with the registered level.
module sync_edge #(
    parameter logic ACT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic q1, q2;

    // Registers hold the normalised level, so reset value 0 means "inactive".
    always_ff @(posedge clk) begin
        if (rst) begin
            q1 <= 1'b0;
            q2 <= 1'b0;
        end else begin
            q1 <= din ~^ ACT;
            q2 <= q1;
        end
    end

    assign level = q1;
    assign rise  = q1 & ~q2;
    assign fall  = ~q1 & q2;

endmodule

// File: rtl/sync_decoder.sv
// Recovers sx/sy, line/frame markers and a geometry lock from an hsync/vsync/de stream.
// Define SYNC_DECODE_STATS_EN to build the h_total/v_total measurement counters.
module sync_decoder
    import sync_decoder_pkg::*;
#(
    parameter int   CORDW       = DEF_CORDW,
    parameter int   H_RES       = DEF_H_RES,
    parameter int   V_RES       = DEF_V_RES,
    parameter logic H_POL       = 1'b0,
    parameter logic V_POL       = 1'b0,
    parameter int   LOCK_FRAMES = 2,
    parameter int   TIMEOUT     = 1000000
) (
    input  logic              clk_pix,
    input  logic              rst,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              de,
    output logic [CORDW-1:0]  sx,
    output logic [CORDW-1:0]  sy,
    output logic              de_o,
    output logic              line,
    output logic              frame,
    output logic              locked,
    output logic [HTOT_W-1:0] h_total,
    output logic [CORDW:0]    v_total
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [CORDW-1:0] CMAX = '1;

    logic hs_lvl, hs_rise, hs_fall;
    logic vs_lvl, vs_rise, vs_fall;
    logic de_lvl, de_rise, de_fall;

    sync_edge #(.ACT(H_POL)) u_hs (
        .clk(clk_pix), .rst(rst), .din(hsync), .level(hs_lvl), .rise(hs_rise), .fall(hs_fall)
    );
    sync_edge #(.ACT(V_POL)) u_vs (
        .clk(clk_pix), .rst(rst), .din(vsync), .level(vs_lvl), .rise(vs_rise), .fall(vs_fall)
    );
    sync_edge #(.ACT(1'b1)) u_de (
        .clk(clk_pix), .rst(rst), .din(de), .level(de_lvl), .rise(de_rise), .fall(de_fall)
    );

    logic [CORDW-1:0]  sx_d, sy_d;
    logic [1:0]        state_q, state_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              bad_q;
    logic              line_bad, frame_good;

    // sy doubles as the frame's line count: it restarts at vsync and counts de falling edges.
    always_comb begin
        sx_d = sx;
        if (de_rise) sx_d = '0;
        else if (de_lvl && sx != CMAX) sx_d = sx + CORDW'(1);
        sy_d = sy;
        if (vs_rise) sy_d = '0;
        else if (de_fall && sy != CMAX) sy_d = sy + CORDW'(1);
    end

    assign line_bad   = de_fall && ((int'(sx) + 1) != H_RES);
    assign frame_good = !bad_q && !de_lvl && (int'(sy) == V_RES);

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        to_d    = to_q;
        if (vs_rise) begin
            to_d = '0;
            case (state_q)
                ST_SEARCH: begin
                    state_d = ST_CHECK;
                    good_d  = '0;
                end
                ST_CHECK: begin
                    if (!frame_good) begin
                        good_d = '0;
                    end else begin
                        good_d = good_q + GOOD_W'(1);
                        if (int'(good_q) + 1 >= LOCK_FRAMES) state_d = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (!frame_good) begin
                        state_d = ST_CHECK;
                        good_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                    good_d  = '0;
                end
            endcase
        end else if (to_q == TO_W'(TIMEOUT - 1)) begin
            state_d = ST_SEARCH;
            good_d  = '0;
            to_d    = '0;
        end else begin
            to_d = to_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            sx      <= '0;
            sy      <= '0;
            de_o    <= 1'b0;
            line    <= 1'b0;
            frame   <= 1'b0;
            locked  <= 1'b0;
            state_q <= ST_SEARCH;
            good_q  <= '0;
            to_q    <= '0;
            bad_q   <= 1'b0;
        end else begin
            sx      <= sx_d;
            sy      <= sy_d;
            de_o    <= de_lvl;
            line    <= de_rise;
            frame   <= locked && de_lvl && (sx_d == '0) && (sy_d == '0);
            locked  <= (state_d == ST_LOCKED);
            state_q <= state_d;
            good_q  <= good_d;
            to_q    <= to_d;
            if (vs_rise) bad_q <= 1'b0;
            else if (line_bad) bad_q <= 1'b1;
        end
    end

    logic unused_edges;

`ifdef SYNC_DECODE_STATS_EN
    logic [HTOT_W-1:0] h_cnt;
    logic [CORDW:0]    v_cnt;

    // h_cnt holds cycles since the last hsync assertion; v_cnt counts hsync edges this frame.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            h_total <= '0;
            v_total <= '0;
        end else begin
            if (hs_rise) begin
                h_total <= h_cnt;
                h_cnt   <= HTOT_W'(1);
            end else if (h_cnt != '1) begin
                h_cnt <= h_cnt + HTOT_W'(1);
            end
            if (vs_rise) begin
                v_total <= v_cnt;
                v_cnt   <= hs_rise ? (CORDW+1)'(1) : '0;
            end else if (hs_rise && v_cnt != '1) begin
                v_cnt <= v_cnt + (CORDW+1)'(1);
            end
        end
    end

    assign unused_edges = ^{hs_lvl, hs_fall, vs_lvl, vs_fall};
`else
    assign h_total      = '0;
    assign v_total      = '0;
    assign unused_edges = ^{hs_lvl, hs_rise, hs_fall, vs_lvl, vs_fall};
`endif

endmodule
